// File: rtl/mem_io_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_io_responder_pkg
// Description : Shared constants for the memory/IO responder: IO page select
//               bit, IO word offsets and UART transmitter state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_io_responder_pkg;

    // Byte-address bit that switches the bus from RAM to the IO page
    localparam int c_io_sel_bit = 22;

    // Word offsets inside the IO page (byte address bits [4:2])
    localparam logic [2:0] c_off_leds        = 3'd0;
    localparam logic [2:0] c_off_uart_data   = 3'd1;
    localparam logic [2:0] c_off_uart_status = 3'd2;
    localparam logic [2:0] c_off_cycles      = 3'd3;

    // UART transmitter frame phases
    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_io_responder_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : 8N1 serial transmitter. A start pulse while idle latches the
//               byte and sends start bit, 8 data bits LSB first, stop bit,
//               each lasting DIVISOR clocks. Starts while busy are dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int DIVISOR = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       start,
    output logic       busy,
    output logic       tx
);
    import mem_io_responder_pkg::*;

    localparam int                 c_cnt_w  = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [c_cnt_w-1:0] c_reload = c_cnt_w'(DIVISOR - 1);
    localparam logic [c_cnt_w-1:0] c_one    = c_cnt_w'(1);

    uart_state_t        r_state;
    uart_state_t        w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [2:0]         r_idx;
    logic [2:0]         w_idx_nxt;
    logic [7:0]         r_data;
    logic [7:0]         w_data_nxt;
    logic               r_tx;
    logic               w_tx_nxt;
    logic               w_bit_done;

    // Frame state and line register; reset abandons any frame in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= UART_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_data  <= w_data_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    // Next-state logic: the bit-time down-counter reloads at every bit boundary
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_data_nxt  = r_data;
        w_tx_nxt    = r_tx;
        w_bit_done  = (r_cnt == '0);
        case (r_state)
            UART_IDLE: begin
                w_tx_nxt = 1'b1;
                if (start) begin
                    w_state_nxt = UART_START;
                    w_cnt_nxt   = c_reload;
                    w_data_nxt  = data;
                    w_tx_nxt    = 1'b0;
                end
            end
            UART_START: begin
                if (w_bit_done) begin
                    w_state_nxt = UART_DATA;
                    w_cnt_nxt   = c_reload;
                    w_idx_nxt   = 3'd0;
                    w_tx_nxt    = r_data[0];
                end else begin
                    w_cnt_nxt = r_cnt - c_one;
                end
            end
            UART_DATA: begin
                if (w_bit_done) begin
                    w_cnt_nxt = c_reload;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = UART_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                        w_tx_nxt  = r_data[r_idx + 3'd1];
                    end
                end else begin
                    w_cnt_nxt = r_cnt - c_one;
                end
            end
            UART_STOP: begin
                if (w_bit_done) begin
                    w_state_nxt = UART_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - c_one;
                end
            end
            default: begin
                w_state_nxt = UART_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    assign busy = (r_state != UART_IDLE);
    assign tx   = r_tx;

endmodule
`default_nettype wire

// File: rtl/mem_io_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_io_responder
// Description : Target side of the processor memory bus. Serves RAM reads and
//               byte-lane writes with 1-cycle read latency (read-before-write)
//               and an IO page with LEDs, UART transmitter and cycle counter.
//               Build option: define IO_UART_EN to include the UART; without
//               it the serial line idles high, status reads 0 and data writes
//               are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int MEM_WORDS   = 1536,
    parameter     INIT_FILE   = "",
    parameter int CLK_FREQ_HZ = 12000000,
    parameter int BAUD        = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr_i,
    input  logic        mem_rstrb_i,
    output logic [31:0] mem_rdata_o,
    input  logic [3:0]  mem_wmask_i,
    input  logic [31:0] mem_wdata_i,
    output logic [4:0]  leds_o,
    output logic        uart_tx_o
);

    localparam int c_aw = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    logic [31:0]     r_mem [0:MEM_WORDS-1];
    logic [31:0]     r_rdata;
    logic [4:0]      r_leds;
    logic [31:0]     r_cycles;

    logic            w_io_sel;
    logic [2:0]      w_io_off;
    logic [29:0]     w_idx_full;
    logic [c_aw-1:0] w_idx;
    logic [31:0]     w_io_rdata;
    logic            w_uart_busy;
    logic            w_unused;

    // Address decode; out-of-range RAM addresses wrap modulo the depth
    assign w_io_sel   = mem_addr_i[c_io_sel_bit];
    assign w_io_off   = mem_addr_i[4:2];
    assign w_idx_full = mem_addr_i[31:2] % 30'(MEM_WORDS);
    assign w_idx      = w_idx_full[c_aw-1:0];
    assign w_unused   = &{1'b0, w_idx_full, mem_addr_i[1:0]};

    // RAM byte-lane writes; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (!w_io_sel) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_wmask_i[i]) begin
                    r_mem[w_idx][8*i +: 8] <= mem_wdata_i[8*i +: 8];
                end
            end
        end
    end

    // IO page read multiplexer; write-only and unmapped offsets read zero
    always_comb begin
        w_io_rdata = '0;
        case (w_io_off)
            c_off_leds:        w_io_rdata = {27'd0, r_leds};
            c_off_uart_status: w_io_rdata = {31'd0, w_uart_busy};
            c_off_cycles:      w_io_rdata = r_cycles;
            default:           w_io_rdata = '0;
        endcase
    end

    // Registered read data: loaded on a strobe with the pre-write word, held otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (mem_rstrb_i) begin
            r_rdata <= w_io_sel ? w_io_rdata : r_mem[w_idx];
        end
    end

    // LED register written through lane 0 of IO offset 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_leds <= '0;
        end else if (w_io_sel && (w_io_off == c_off_leds) && mem_wmask_i[0]) begin
            r_leds <= mem_wdata_i[4:0];
        end
    end

    // Free-running cycle counter, wraps naturally at 32 bits
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycles <= '0;
        end else begin
            r_cycles <= r_cycles + 32'd1;
        end
    end

`ifdef IO_UART_EN
    localparam int c_div_raw = CLK_FREQ_HZ / BAUD;
    localparam int c_divisor = (c_div_raw < 1) ? 1 : c_div_raw;

    logic w_uart_start;
    logic w_uart_tx;

    assign w_uart_start = w_io_sel && (w_io_off == c_off_uart_data) && mem_wmask_i[0];

    uart_tx #(
        .DIVISOR (c_divisor)
    ) u_uart_tx (
        .clk   (clk),
        .rst   (rst),
        .data  (mem_wdata_i[7:0]),
        .start (w_uart_start),
        .busy  (w_uart_busy),
        .tx    (w_uart_tx)
    );

    assign uart_tx_o = w_uart_tx;
`else
    assign w_uart_busy = 1'b0;
    assign uart_tx_o   = 1'b1;
`endif

    assign mem_rdata_o = r_rdata;
    assign leds_o      = r_leds;

endmodule
`default_nettype wire
